period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter EXP_HALF, 25000, expected half-period of CLK_IN in CLK cycles.
REQ-002 Parameter TOL, 2, allowed absolute deviation from EXP_HALF in CLK cycles.
REQ-003 Parameter LOCK_N, 4, consecutive in-tolerance measurements required to assert LOCKED.
REQ-004 Parameter TIMEOUT, 60000, CLK cycles without a CLK_IN edge before STALL is declared; SHALL be > EXP_HALF+TOL and < 65535.
REQ-005 CLK  input  1  single system clock; all state on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 CLK_IN  input  1  slow divided clock under measurement, asynchronous to CLK.
REQ-008 EN  input  1  measurement enable, synchronous to CLK.
REQ-009 HALF_CNT  output  16  last measured half-period in CLK cycles.
REQ-010 VALID  output  1  one-cycle pulse when HALF_CNT updates.
REQ-011 LOCKED  output  1  CLK_IN period stable within tolerance.
REQ-012 STALL  output  1  no CLK_IN edge within TIMEOUT cycles.
REQ-013 ERR_CNT  output  8  saturating count of out-of-tolerance measurements.

Function
REQ-014 CLK_IN SHALL pass through a 2-flop synchronizer; a third flop SHALL provide edge detection, and both rising and falling synchronized edges SHALL count as EDGE.
REQ-015 FSM states: IDLE, ARM, MEAS.
REQ-016 IDLE: counter held at 0, no VALID; EN=1 -> ARM next cycle.
REQ-017 ARM: waits for first EDGE; on EDGE, CNT <= 1 and state -> MEAS; no measurement is reported for this edge.
REQ-018 MEAS, no EDGE: CNT <= CNT+1; when CNT reaches TIMEOUT, STALL <= 1, LOCKED <= 0, good-run count <= 0, state -> ARM.
REQ-019 MEAS, EDGE: HALF_CNT <= CNT, VALID <= 1 for exactly one cycle, CNT <= 1, STALL <= 0.
REQ-020 In-tolerance test: EXP_HALF-TOL <= CNT <= EXP_HALF+TOL, evaluated on the CNT value latched into HALF_CNT.
REQ-021 In-tolerance measurement: good-run count increments, saturating at LOCK_N; LOCKED <= 1 in the same cycle the count reaches LOCK_N.
REQ-022 Out-of-tolerance measurement: good-run count <= 0, LOCKED <= 0, ERR_CNT increments, saturating at 255.
REQ-023 STALL, once set, SHALL remain high until the next EDGE in ARM or a reset; it SHALL not increment ERR_CNT.
REQ-024 EN=0 in any state: state -> IDLE next cycle, LOCKED <= 0, good-run count <= 0, VALID <= 0; HALF_CNT, STALL, ERR_CNT hold their values.
REQ-025 EDGE coinciding with CNT == TIMEOUT: the EDGE SHALL take priority and be treated as a normal measurement.
REQ-026 Synchronizer latency SHALL be constant, so measured HALF_CNT equals the true half-period in CLK cycles.

Reset
REQ-027 RST=1 SHALL immediately force state IDLE, HALF_CNT=0, VALID=0, LOCKED=0, STALL=0, ERR_CNT=0, CNT=0, good-run count=0, and synchronizer flops=0.
REQ-028 Reset deassertion mid-measurement SHALL restart from IDLE; no partial measurement SHALL be reported.

Verification
REQ-029 EN=1, CLK_IN toggling every 25000 CLK cycles -> VALID once per 25000 cycles, HALF_CNT=25000, LOCKED rises on the 4th VALID, ERR_CNT=0.
REQ-030 Locked, one half-period stretched to 25003 -> that VALID gives HALF_CNT=25003, LOCKED=0, ERR_CNT=1; LOCKED returns after 4 further 25000-cycle halves.
REQ-031 Locked, CLK_IN frozen -> STALL=1 and LOCKED=0 exactly 60000 cycles after the last EDGE; the first new edge clears STALL with no VALID; the second edge produces VALID.
REQ-032 300 consecutive 24990-cycle halves -> ERR_CNT saturates at 255, LOCKED stays 0.
REQ-033 EN dropped while locked, then raised -> LOCKED=0 immediately, HALF_CNT retained, first VALID only after the second edge following re-enable.
REQ-034 RST pulsed mid-half-period while locked -> all outputs 0 at once; after release, behaviour is identical to REQ-029 from first edge.

Source files
------------

// File: rtl/period_meter_if.sv
// Measurement bus between the period meter and its user: slow clock and enable in,
// half-period result and status flags out.
interface period_meter_if;
  logic        clk_in;
  logic        en;
  logic [15:0] half_cnt;
  logic        valid;
  logic        locked;
  logic        stall;
  logic [7:0]  err_cnt;

  modport master (
    output clk_in, en,
    input  half_cnt, valid, locked, stall, err_cnt
  );

  modport slave (
    input  clk_in, en,
    output half_cnt, valid, locked, stall, err_cnt
  );
endinterface

// File: rtl/period_meter.sv
// Measures each half-period of an asynchronous slow clock in core cycles, tracks lock
// against an expected value, flags a stalled input, and counts out-of-tolerance halves.
module period_meter #(
  parameter int unsigned EXP_HALF = 25000,
  parameter int unsigned TOL      = 2,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned TIMEOUT  = 60000
) (
  input  logic         clk,
  input  logic         rst,
  period_meter_if.slave bus
);

  localparam int unsigned GW = $clog2(LOCK_N + 1);
  localparam logic [15:0] LO_LIM   = 16'(EXP_HALF - TOL);
  localparam logic [15:0] HI_LIM   = 16'(EXP_HALF + TOL);
  localparam logic [15:0] TO_LIM   = 16'(TIMEOUT);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_N);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync_q, sync_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [15:0]   half_cnt_q, half_cnt_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          stall_q, stall_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          edge_det;
  logic          in_tol;
  logic [GW-1:0] good_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      cnt_q      <= '0;
      good_q     <= '0;
      half_cnt_q <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      stall_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      half_cnt_q <= half_cnt_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      stall_q    <= stall_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Two synchronizer stages then a compare stage: fixed latency on both edge polarities.
  assign edge_det = sync_q[1] ^ sync_q[2];
  assign in_tol   = (cnt_q >= LO_LIM) && (cnt_q <= HI_LIM);
  assign good_inc = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;

  always_comb begin
    sync_d     = {sync_q[1:0], bus.clk_in};
    state_d    = state_q;
    cnt_d      = cnt_q;
    good_d     = good_q;
    half_cnt_d = half_cnt_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    stall_d    = stall_q;
    err_cnt_d  = err_cnt_q;

    if (!bus.en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (edge_det) begin
            cnt_d   = 16'd1;
            stall_d = 1'b0;
            state_d = MEAS;
          end
        end
        MEAS: begin
          // An edge on the timeout cycle still counts as a measurement.
          if (edge_det) begin
            half_cnt_d = cnt_q;
            valid_d    = 1'b1;
            cnt_d      = 16'd1;
            stall_d    = 1'b0;
            if (in_tol) begin
              good_d   = good_inc;
              locked_d = (good_inc == GOOD_MAX);
            end else begin
              good_d    = '0;
              locked_d  = 1'b0;
              err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            end
          end else if (cnt_q == TO_LIM) begin
            stall_d  = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            cnt_d    = '0;
            state_d  = ARM;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.half_cnt = half_cnt_q;
  assign bus.valid    = valid_q;
  assign bus.locked   = locked_q;
  assign bus.stall    = stall_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: stimulus pushes expected results, a monitor checks each VALID.
module tb_period_meter;
  localparam int EXP  = 50;
  localparam int TOLV = 2;
  localparam int LOCKN = 4;
  localparam int TMO  = 130;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  period_meter_if bus();

  period_meter #(
    .EXP_HALF(EXP),
    .TOL(TOLV),
    .LOCK_N(LOCKN),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [15:0] half;
    logic        locked;
    logic [7:0]  err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e, mon_a;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait n cycles then toggle clk_in; optionally register the VALID this edge should produce.
  task automatic half(input int n, input bit exp_v, input logic [15:0] h,
                      input bit l, input logic [7:0] e);
    exp_t t;
    cyc(n);
    if (exp_v) begin
      t.half = h;
      t.locked = l;
      t.err = e;
      sb_q.push_back(t);
    end
    bus.clk_in = ~bus.clk_in;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: half_cnt=%0d locked=%0b err_cnt=%0d, expected no VALID",
                 bus.half_cnt, bus.locked, bus.err_cnt);
      end else begin
        mon_e = sb_q.pop_front();
        mon_a.half = bus.half_cnt;
        mon_a.locked = bus.locked;
        mon_a.err = bus.err_cnt;
        if (mon_a !== mon_e) begin
          n_bad++;
          $display("FAIL valid_result: got half=%0d locked=%0b err=%0d, expected half=%0d locked=%0b err=%0d",
                   mon_a.half, mon_a.locked, mon_a.err, mon_e.half, mon_e.locked, mon_e.err);
        end
      end
    end
  end

  initial begin
    bus.clk_in = 1'b0;
    bus.en = 1'b0;
    #1;
    chk("rst_half_cnt", bus.half_cnt, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    cyc(3);
    rst = 1'b0;
    cyc(3);
    bus.en = 1'b1;
    cyc(5);

    // Lock-up, including both tolerance edges 52 and 48.
    half(1, 0, 0, 0, 0);
    half(50, 1, 50, 0, 0);
    half(52, 1, 52, 0, 0);
    half(48, 1, 48, 0, 0);
    half(50, 1, 50, 1, 0);
    half(50, 1, 50, 1, 0);
    half(50, 1, 50, 1, 0);

    // One stretched half breaks lock; four good halves restore it.
    half(53, 1, 53, 0, 1);
    half(50, 1, 50, 0, 1);
    half(50, 1, 50, 0, 1);
    half(50, 1, 50, 0, 1);
    half(50, 1, 50, 1, 1);

    // Frozen input: stall exactly when the counter hits the timeout.
    cyc(TMO + 2);
    chk("stall_before_timeout", bus.stall, 0);
    chk("locked_before_timeout", bus.locked, 1);
    cyc(1);
    chk("stall_at_timeout", bus.stall, 1);
    chk("locked_at_timeout", bus.locked, 0);
    chk("err_after_stall", bus.err_cnt, 1);
    half(10, 0, 0, 0, 0);
    cyc(5);
    chk("stall_cleared_by_edge", bus.stall, 0);
    half(45, 1, 50, 0, 1);

    // Edge landing on the timeout cycle is a measurement, not a stall.
    half(TMO, 1, 16'(TMO), 0, 2);
    cyc(5);
    chk("stall_edge_priority", bus.stall, 0);

    // Persistent short halves saturate the error counter.
    err_m = 2;
    for (int i = 0; i < 300; i++) begin
      err_m = (err_m < 255) ? err_m + 1 : 255;
      half((i == 0) ? 42 : 47, 1, 47, 0, 8'(err_m));
    end
    half(50, 1, 50, 0, 255);
    half(50, 1, 50, 0, 255);
    half(50, 1, 50, 0, 255);
    half(50, 1, 50, 1, 255);

    // Enable drop while locked.
    cyc(20);
    chk("locked_pre_en_drop", bus.locked, 1);
    bus.en = 1'b0;
    cyc(1);
    chk("en_drop_locked", bus.locked, 0);
    chk("en_drop_half_cnt", bus.half_cnt, 50);
    chk("en_drop_err_cnt", bus.err_cnt, 255);
    cyc(10);
    bus.en = 1'b1;
    cyc(5);
    half(1, 0, 0, 0, 0);
    half(50, 1, 50, 0, 255);
    half(50, 1, 50, 0, 255);
    half(50, 1, 50, 0, 255);
    half(50, 1, 50, 1, 255);

    // Reset mid-half while locked, with clk_in low.
    if (bus.clk_in) half(50, 1, 50, 1, 255);
    cyc(20);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_half_cnt", bus.half_cnt, 0);
    chk("midrst_valid", bus.valid, 0);
    chk("midrst_locked", bus.locked, 0);
    chk("midrst_stall", bus.stall, 0);
    chk("midrst_err_cnt", bus.err_cnt, 0);
    cyc(2);
    rst = 1'b0;
    cyc(5);
    half(1, 0, 0, 0, 0);
    half(50, 1, 50, 0, 0);
    half(50, 1, 50, 0, 0);
    half(50, 1, 50, 0, 0);
    half(50, 1, 50, 1, 0);
    half(50, 1, 50, 1, 0);

    cyc(10);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
